// File: rtl/inst_fifo.sv
// Dual-issue instruction buffer: up to two pushes and two pops per cycle, with flush.
// The decoders see the two oldest entries as combinational reads at head and head+1.
module inst_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push_en0,
    input  logic [31:0]       push_inst0,
    input  logic [31:0]       push_pc0,
    input  logic              push_en1,
    input  logic [31:0]       push_inst1,
    input  logic [31:0]       push_pc1,
    input  logic              pop_master,
    input  logic              pop_slave,
    output logic              master_valid,
    output logic [31:0]       master_inst,
    output logic [31:0]       master_pc,
    output logic              slave_valid,
    output logic [31:0]       slave_inst,
    output logic [31:0]       slave_pc,
    output logic              empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(DEPTH);

    logic [31:0]       inst_mem [DEPTH];
    logic [31:0]       pc_mem   [DEPTH];

    logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic [1:0]        npush, npop, npush_acc;
    logic [ADDR_W:0]   free;
    logic              push_ok;
    logic [ADDR_W-1:0] head_p1, tail_p1, wr1_addr;
    logic              wr0, wr1;

    assign head_p1 = head_q + ADDR_W'(1);
    assign tail_p1 = tail_q + ADDR_W'(1);

    // Admission uses occupancy at the start of the cycle; same-cycle pops never make room.
    always_comb begin
        npush     = {1'b0, push_en0} + {1'b0, push_en1};
        free      = CAP - count_q;
        push_ok   = (ADDR_W+1)'(npush) <= free;
        npush_acc = push_ok ? npush : 2'd0;

        npop = 2'd0;
        if (pop_master && master_valid) begin
            npop = 2'd1;
            if (pop_slave && slave_valid) npop = 2'd2;
        end

        head_d  = head_q + ADDR_W'(npop);
        tail_d  = tail_q + ADDR_W'(npush_acc);
        count_d = count_q + (ADDR_W+1)'(npush_acc) - (ADDR_W+1)'(npop);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    assign wr0      = push_ok && !flush && push_en0;
    assign wr1      = push_ok && !flush && push_en1;
    assign wr1_addr = push_en0 ? tail_p1 : tail_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage has no reset; count qualifies every read, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (wr0) begin
            inst_mem[tail_q] <= push_inst0;
            pc_mem[tail_q]   <= push_pc0;
        end
        if (wr1) begin
            inst_mem[wr1_addr] <= push_inst1;
            pc_mem[wr1_addr]   <= push_pc1;
        end
    end

    always_comb begin
        master_valid = count_q != '0;
        slave_valid  = count_q >= (ADDR_W+1)'(2);
        master_inst  = master_valid ? inst_mem[head_q]  : 32'h0;
        master_pc    = master_valid ? pc_mem[head_q]    : 32'h0;
        slave_inst   = slave_valid  ? inst_mem[head_p1] : 32'h0;
        slave_pc     = slave_valid  ? pc_mem[head_p1]   : 32'h0;
        empty        = count_q == '0;
        almost_full  = free < (ADDR_W+1)'(2);
        count        = count_q;
    end

endmodule
